// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a 16-byte block (eight 16-bit words) from main memory after a cache miss.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   miss_detected       lookup missed; sampled only in IDLE
//   miss_address        byte address of the miss; bits [ADDR_WIDTH-1:4] form the block base
//   memory_data_valid   one returned word this cycle; ignored in IDLE
//   fsm_busy            fill in progress (pipeline stall)
//   mem_read            word read request, with memory_address as its word address (0 when idle)
//   write_data_array    write the returned word at byte offset write_word_offset
//   write_tag_array     single-cycle pulse on the last word, commits tag/valid for the block
//   fill_count          completed fills, saturating; present only with CACHE_FILL_PERF_CNT_EN
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic [3:0]            write_word_offset,
    output logic                  write_tag_array
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    output logic [15:0]           fill_count
`endif
);
    localparam logic [3:0] LAST_REQ = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0] LAST_RCV = 3'(WORDS_PER_BLOCK - 1);
    typedef enum logic {IDLE, FILL} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-5:0] base_q, base_d;
    logic [3:0]            req_cnt_q, req_cnt_d;
    logic [2:0]            rcv_cnt_q, rcv_cnt_d;
    logic                  unused_bits;
    // Byte-within-block bits never reach the block base.
    assign unused_bits = ^miss_address[3:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end
    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        req_cnt_d         = req_cnt_q;
        rcv_cnt_d         = rcv_cnt_q;
        fsm_busy          = state_q == FILL;
        mem_read          = fsm_busy && (req_cnt_q < LAST_REQ);
        memory_address    = mem_read ? {base_q, req_cnt_q[2:0], 1'b0} : '0;
        write_data_array  = fsm_busy && memory_data_valid;
        write_word_offset = {rcv_cnt_q, 1'b0};
        write_tag_array   = write_data_array && (rcv_cnt_q == LAST_RCV);
        if (state_q == IDLE) begin
            state_d   = miss_detected ? FILL : IDLE;
            base_d    = miss_detected ? miss_address[ADDR_WIDTH-1:4] : base_q;
            req_cnt_d = '0;
            rcv_cnt_d = '0;
        end else begin
            // Requests may run ahead of returned data; the last word ends the fill
            // and clears both counters so the next fill starts cleanly.
            req_cnt_d = write_tag_array ? 4'd0 : (mem_read ? req_cnt_q + 4'd1 : req_cnt_q);
            rcv_cnt_d = write_tag_array ? 3'd0 : (write_data_array ? rcv_cnt_q + 3'd1 : rcv_cnt_q);
            state_d   = write_tag_array ? IDLE : FILL;
        end
    end
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count_q, fill_count_d;
    always_ff @(posedge clk) begin
        if (rst) fill_count_q <= '0;
        else     fill_count_q <= fill_count_d;
    end
    always_comb begin
        fill_count_d = (write_tag_array && fill_count_q != 16'hFFFF) ? fill_count_q + 16'd1 : fill_count_q;
    end
    assign fill_count = fill_count_q;
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for cache_fill_fsm with directed fills.
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy, mem_read, write_data_array, write_tag_array;
    logic [15:0] memory_address;
    logic [3:0]  write_word_offset;
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count;
`endif
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_fills = 0;
    int          busy_run = 0;
    logic [15:0] addr_q[$];
    logic [4:0]  wr_q[$];
    int          busy_q[$];

    cache_fill_fsm dut (
        .clk(clk),
        .rst(rst),
        .miss_detected(miss_detected),
        .miss_address(miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy(fsm_busy),
        .mem_read(mem_read),
        .memory_address(memory_address),
        .write_data_array(write_data_array),
        .write_word_offset(write_word_offset),
        .write_tag_array(write_tag_array)
`ifdef CACHE_FILL_PERF_CNT_EN
        ,
        .fill_count(fill_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 0);
        chk({tag, "_mem_read"}, 32'(mem_read), 0);
        chk({tag, "_address"}, 32'(memory_address), 0);
        chk({tag, "_wr_data"}, 32'(write_data_array), 0);
        chk({tag, "_offset"}, 32'(write_word_offset), 0);
        chk({tag, "_wr_tag"}, 32'(write_tag_array), 0);
    endtask

    // Monitor: pops expected traffic whenever the DUT presents it.
    always @(negedge clk) begin
        if (mem_read) begin
            chk("mem_read_expected", 32'(addr_q.size() > 0), 1);
            if (addr_q.size() > 0) chk("memory_address", 32'(memory_address), 32'(addr_q.pop_front()));
        end else begin
            chk("address_zero_without_read", 32'(memory_address), 0);
        end
        if (write_data_array) begin
            chk("write_expected", 32'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) chk("offset_and_tag", 32'({write_word_offset, write_tag_array}), 32'(wr_q.pop_front()));
        end else begin
            chk("tag_without_write", 32'(write_tag_array), 0);
        end
        if (fsm_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            chk("busy_run_expected", 32'(busy_q.size() > 0), 1);
            if (busy_q.size() > 0) chk("busy_cycles", 32'(busy_run), 32'(busy_q.pop_front()));
            busy_run = 0;
        end
    end

    // Cycle 0 presents the miss; data words arrive from cycle 'first' every gap+1 cycles.
    // rst_c > 0 asserts reset during that cycle, aborting the fill.
    task automatic run_fill(input logic [15:0] a, input logic [15:0] busy_a, input bit busy_miss,
                            input int first, input int gap, input int nwords, input int rst_c, input bit hold);
        int          last = first + (nwords - 1) * (gap + 1);
        int          stop = (rst_c > 0) ? rst_c : last;
        int          nreq = (rst_c > 0 && rst_c < 8) ? rst_c : 8;
        int          sent = 0;
        logic [15:0] base = a & 16'hFFF0;
        for (int i = 0; i < nreq; i++) addr_q.push_back(base + 16'(2 * i));
        for (int i = 0; i < nwords; i++) wr_q.push_back({4'(2 * i), 1'(i == 7)});
        busy_q.push_back(stop);
        if (rst_c > 0) exp_fills = 0;
        else if (nwords == 8) exp_fills++;
        miss_detected = 1'b1;
        miss_address = a;
        memory_data_valid = 1'b0;
        @(negedge clk);
        chk("busy_low_on_miss_cycle", 32'(fsm_busy), 0);
        cyc();
        for (int c = 1; c <= stop; c++) begin
            miss_detected = hold | busy_miss;
            miss_address = busy_miss ? busy_a : a;
            memory_data_valid = (sent < nwords) && (c >= first) && ((c - first) % (gap + 1) == 0);
            if (memory_data_valid) sent++;
            rst = (c == rst_c);
            cyc();
        end
        memory_data_valid = 1'b0;
        miss_detected = hold;
        if (rst_c > 0) begin
            @(negedge clk);
            chk_zero("after_reset");
            rst = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc();
        cyc();
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        cyc();
        // Basic fill, latency 4.
        run_fill(16'h1A36, 16'h0000, 1'b0, 5, 0, 8, 0, 1'b0);
        cyc();
        // Miss held during the fill with a different address.
        run_fill(16'h1A36, 16'hFFF0, 1'b1, 5, 0, 8, 0, 1'b0);
        cyc();
        // Gapped data.
        run_fill(16'h3C5A, 16'h0000, 1'b0, 5, 1, 8, 0, 1'b0);
        cyc();
        // Minimum latency and top of the address space.
        run_fill(16'hFFFF, 16'h0000, 1'b0, 2, 0, 8, 0, 1'b0);
        cyc();
        // Reset after the third word, then a fresh fill.
        run_fill(16'h5550, 16'h0000, 1'b0, 5, 0, 3, 8, 1'b0);
        run_fill(16'h0040, 16'h0000, 1'b0, 4, 0, 8, 0, 1'b0);
        cyc();
        // Stray data in IDLE.
        memory_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_wr_data", 32'(write_data_array), 0);
            chk("stray_busy", 32'(fsm_busy), 0);
            cyc();
        end
        memory_data_valid = 1'b0;
        run_fill(16'h0100, 16'h0000, 1'b0, 3, 2, 8, 0, 1'b0);
        cyc();
        // Back-to-back fills with miss held high, after a clean reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_fills = 0;
        cyc();
        run_fill(16'h2000, 16'h0000, 1'b0, 5, 0, 8, 0, 1'b1);
        run_fill(16'h2A18, 16'h0000, 1'b0, 5, 0, 8, 0, 1'b0);
        cyc();
        cyc();
        cyc();
`ifdef CACHE_FILL_PERF_CNT_EN
        chk("fill_count", 32'(fill_count), 32'(exp_fills));
`endif
        chk("addr_queue_drained", 32'(addr_q.size()), 0);
        chk("write_queue_drained", 32'(wr_q.size()), 0);
        chk("busy_queue_drained", 32'(busy_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the address width.
REQ-003 Parameter WORDS_PER_BLOCK, default 8, SHALL set the 16-bit words fetched per 16-byte block; only 8 is supported.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: miss_detected  input  1  cache lookup missed this cycle.
REQ-007 Port: miss_address  input  ADDR_WIDTH  byte address of the missing access.
REQ-008 Port: memory_data_valid  input  1  main memory returns one word this cycle.
REQ-009 Port: fsm_busy  output  1  a fill is in progress; the cache stalls the pipeline.
REQ-010 Port: mem_read  output  1  read request to main memory this cycle.
REQ-011 Port: memory_address  output  ADDR_WIDTH  word address of the current request.
REQ-012 Port: write_data_array  output  1  write the returned word into the data array.
REQ-013 Port: write_word_offset  output  4  byte offset (addr[3:0]) of the word being written.
REQ-014 Port: write_tag_array  output  1  one-cycle pulse that writes tag/valid metadata for the filled block.

Function
REQ-015 The FSM SHALL have two states, IDLE and FILL.
REQ-016 In IDLE, when miss_detected=1 at a clock edge, the block SHALL latch miss_address[15:4] as the block base and enter FILL on the next cycle.
REQ-017 Request counter req_cnt (0..8) SHALL start at 0 on entry to FILL.
- mem_read=1 while in FILL with req_cnt<8; req_cnt increments each such cycle.
- Requests are issued on 8 consecutive cycles, back to back.
REQ-018 memory_address SHALL equal {base, req_cnt[2:0], 1'b0} while mem_read=1, and SHALL be 0 otherwise.
REQ-019 Receive counter rcv_cnt (0..7) SHALL increment on each memory_data_valid while in FILL.
REQ-020 write_data_array SHALL equal memory_data_valid AND (state==FILL), combinationally, with write_word_offset={rcv_cnt,1'b0}.
REQ-021 When memory_data_valid=1 and rcv_cnt=7, write_tag_array SHALL pulse high in that same cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-022 fsm_busy SHALL be 1 exactly while the state is FILL, and SHALL not be asserted in the cycle miss_detected is first sampled.
REQ-023 miss_detected asserted while in FILL SHALL be ignored; the latched base SHALL not change.
REQ-024 memory_data_valid while in IDLE SHALL be ignored: no array writes and no counter change.
REQ-025 A miss_detected that is high in the cycle after returning to IDLE SHALL start a new fill; there are no dead cycles beyond the IDLE cycle.
REQ-026 Counters SHALL not wrap.
- req_cnt saturates at 8.
- memory_data_valid beyond the 8th word cannot occur in FILL, because the FSM has already left FILL.
REQ-027 Correct operation SHALL not depend on memory latency; any latency of 1 or more cycles, including gaps between valid words, SHALL be tolerated.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL reset to:
- state=IDLE, req_cnt=0, rcv_cnt=0, base=0.
- All outputs 0: fsm_busy, mem_read, memory_address, write_data_array, write_word_offset, write_tag_array.
REQ-029 Reset asserted mid-fill SHALL abort the fill, with no write_tag_array pulse, so the partial block stays invalid.

Configuration
REQ-030 With macro CACHE_FILL_PERF_CNT_EN defined, the block SHALL add output fill_count (16 bits).
- Increments on each write_tag_array pulse.
- Saturates at 16'hFFFF.
- Cleared by rst.
REQ-031 Without CACHE_FILL_PERF_CNT_EN, port fill_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Basic fill: reset, then miss_detected=1 with miss_address=16'h1A36, memory latency 4 cycles.
- mem_read is high for 8 cycles with memory_address 16'h1A30, 16'h1A32, ..., 16'h1A3E.
- 8 write_data_array pulses occur with offsets 0, 2, ..., 14.
- write_tag_array pulses with the 8th pulse; fsm_busy is high for 12 cycles.
REQ-033 Busy miss: during the fill above, drive miss_address=16'hFFF0 with miss_detected=1.
- All memory_address values still use base 16'h1A3.
REQ-034 Gapped data: memory_data_valid is returned with 1-cycle gaps.
- Offsets still run in order 0 through 14.
- write_tag_array fires only on the 8th word.
REQ-035 Reset mid-fill: assert rst after the 3rd word.
- All outputs are 0 on the next cycle.
- No write_tag_array pulse occurs.
- A new miss at 16'h0040 fetches 16'h0040 through 16'h004E.
REQ-036 Back-to-back: miss_detected held high continuously.
- The second fill starts one IDLE cycle after the first fill's write_tag_array pulse.
- With CACHE_FILL_PERF_CNT_EN defined, fill_count reads 2 after both fills.
REQ-037 Stray data: memory_data_valid=1 in IDLE.
- write_data_array stays 0 and the counters are unchanged.
